// File: rtl/router_pkg.sv
// router_pkg
// Shared router definitions: port index constants in [c,n,e,s,w] order,
// the default port count, and the per-output allocator state type.
package router_pkg;

  localparam int NUM_PORTS = 5;

  localparam int PORT_C = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_S = 3;
  localparam int PORT_W = 4;

  // Per-output allocator state
  //   ALLOC_IDLE   | output free, heads arbitrate round-robin
  //   ALLOC_LOCKED | output held by its owner until the owner's tail passes
  typedef enum logic {
    ALLOC_IDLE   = 1'b0,
    ALLOC_LOCKED = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin arbiter. Picks the first asserted request
// at or after i_ptr, wrapping from N-1 back to 0.
// Ports:
//   i_req   [N-1:0]  request vector, bit i = requester i
//   i_ptr   [IW-1:0] highest-priority requester index
//   o_grant [N-1:0]  one-hot grant (all zero when no request)
//   o_idx   [IW-1:0] index of the granted requester (0 when none)
//   o_any            at least one request present
module rr_arbiter #(
  parameter  int N  = 5,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int w_cand;

  // Scan from the farthest offset down to offset 0 so the closest requester
  // to the pointer is the last (winning) assignment.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= N) w_cand = w_cand - N;
      if (i_req[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = IW'(w_cand);
        o_grant         = '0;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// switch_allocator
// Wormhole switch allocator. Each output runs an IDLE/LOCKED FSM with an
// owner index and a round-robin pointer; grants are combinational in the
// same cycle as the request.
// Ports:
//   i_clk, i_reset_n             clock, async active-low reset
//   i_val/i_head/i_tail [0:M-1]  per-input flit valid / head / tail
//   i_output_req [0:M-1][0:M-1]  one-hot output request of each input
//   i_en [0:M-1]                 output may accept a flit this cycle
//   o_input_grant [0:M-1]        input flit transferred this cycle
//   o_output_val  [0:M-1]        output carries a flit this cycle
//   o_xbar_sel    [0:M-1][IW-1:0] input driving each output (0 if idle)
//
// State table (per output j):
//   ALLOC_IDLE   | heads compete from r_ptr; head-only winner locks the output
//   ALLOC_LOCKED | only r_owner may send; its tail returns the output to IDLE
module switch_allocator
  import router_pkg::*;
#(
  parameter  int M  = NUM_PORTS,
  localparam int IW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [0:M-1]         i_val,
  input  logic [0:M-1]         i_head,
  input  logic [0:M-1]         i_tail,
  input  logic [0:M-1][0:M-1]  i_output_req,
  input  logic [0:M-1]         i_en,
  output logic [0:M-1]         o_input_grant,
  output logic [0:M-1]         o_output_val,
  output logic [0:M-1][IW-1:0] o_xbar_sel
);

  alloc_state_t  r_state [M];
  logic [IW-1:0] r_owner [M];
  logic [IW-1:0] r_ptr   [M];

  logic [M-1:0]  w_head_req [M];
  logic [M-1:0]  w_arb_gnt  [M];
  logic [IW-1:0] w_arb_idx  [M];
  logic          w_arb_any  [M];

  logic [M-1:0]  w_win_oh [M];
  logic [IW-1:0] w_win    [M];
  logic          w_oval   [M];

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(M - 1)) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    for (int j = 0; j < M; j++) begin
      w_head_req[j] = '0;
      for (int i = 0; i < M; i++)
        w_head_req[j][i] = i_val[i] & i_head[i] & i_output_req[i][j];
    end
  end

  for (genvar g = 0; g < M; g++) begin : g_arb
    rr_arbiter #(.N(M)) u_arb (
      .i_req   (w_head_req[g]),
      .i_ptr   (r_ptr[g]),
      .o_grant (w_arb_gnt[g]),
      .o_idx   (w_arb_idx[g]),
      .o_any   (w_arb_any[g])
    );
  end

  // Grants are gated by i_reset_n so outputs are quiet throughout reset,
  // not only after the registers have cleared.
  always_comb begin
    o_input_grant = '0;
    o_output_val  = '0;
    o_xbar_sel    = '0;
    for (int j = 0; j < M; j++) begin
      w_win_oh[j] = '0;
      w_win[j]    = '0;
      w_oval[j]   = 1'b0;
      if (r_state[j] == ALLOC_LOCKED) begin
        w_win[j]              = r_owner[j];
        w_win_oh[j][r_owner[j]] = 1'b1;
        w_oval[j]             = i_en[j] & i_val[r_owner[j]]
                                & i_output_req[r_owner[j]][j];
      end else begin
        w_win[j]    = w_arb_idx[j];
        w_win_oh[j] = w_arb_gnt[j];
        w_oval[j]   = i_en[j] & w_arb_any[j];
      end
      w_oval[j]       = w_oval[j] & i_reset_n;
      o_output_val[j] = w_oval[j];
      if (w_oval[j]) o_xbar_sel[j] = w_win[j];
      for (int i = 0; i < M; i++)
        o_input_grant[i] = o_input_grant[i] | (w_oval[j] & w_win_oh[j][i]);
    end
  end

  // Pointer advances only on IDLE grants, so a packet's body flits never
  // disturb the fairness order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int j = 0; j < M; j++) begin
        r_state[j] <= ALLOC_IDLE;
        r_owner[j] <= '0;
        r_ptr[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < M; j++) begin
        if (w_oval[j]) begin
          if (r_state[j] == ALLOC_IDLE) begin
            r_ptr[j] <= next_idx(w_win[j]);
            if (!i_tail[w_win[j]]) begin
              r_state[j] <= ALLOC_LOCKED;
              r_owner[j] <= w_win[j];
            end
          end else if (i_tail[w_win[j]]) begin
            r_state[j] <= ALLOC_IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator
// Directed scenarios followed by random traffic, checked against a
// packet-level reference model of the allocation rules.
module tb_switch_allocator;

  localparam int M  = 5;
  localparam int IW = $clog2(M);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [0:M-1]         val, head, tail, en;
  logic [0:M-1][0:M-1]  oreq;
  logic [0:M-1]         o_input_grant, o_output_val;
  logic [0:M-1][IW-1:0] o_xbar_sel;

  int total = 0;
  int bad   = 0;

  bit m_lock [M];
  int m_own  [M];
  int m_ptr  [M];
  bit m_g    [M];
  int m_w    [M];
  logic [0:M-1]         e_ig, e_ov;
  logic [0:M-1][IW-1:0] e_sel;

  always #5 clk = ~clk;

  switch_allocator #(.M(M)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_val         (val),
    .i_head        (head),
    .i_tail        (tail),
    .i_output_req  (oreq),
    .i_en          (en),
    .o_input_grant (o_input_grant),
    .o_output_val  (o_output_val),
    .o_xbar_sel    (o_xbar_sel)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs: locked outputs serve only their owner; free outputs
  // take the first head at or after the pointer (modulo M).
  function automatic void model_eval();
    e_ig = '0; e_ov = '0; e_sel = '0;
    for (int j = 0; j < M; j++) begin
      m_g[j] = 1'b0;
      m_w[j] = 0;
      if (rst_n && en[j]) begin
        if (m_lock[j]) begin
          if (val[m_own[j]] && oreq[m_own[j]][j]) begin
            m_g[j] = 1'b1;
            m_w[j] = m_own[j];
          end
        end else begin
          for (int k = 0; k < M; k++) begin
            int i;
            i = (m_ptr[j] + k) % M;
            if (!m_g[j] && val[i] && head[i] && oreq[i][j]) begin
              m_g[j] = 1'b1;
              m_w[j] = i;
            end
          end
        end
      end
      if (m_g[j]) begin
        e_ov[j]       = 1'b1;
        e_sel[j]      = IW'(m_w[j]);
        e_ig[m_w[j]]  = 1'b1;
      end
    end
  endfunction

  function automatic void model_update();
    for (int j = 0; j < M; j++) begin
      if (!rst_n) begin
        m_lock[j] = 1'b0;
        m_own[j]  = 0;
        m_ptr[j]  = 0;
      end else if (m_g[j]) begin
        if (!m_lock[j]) begin
          m_ptr[j] = (m_w[j] + 1) % M;
          if (!tail[m_w[j]]) begin
            m_lock[j] = 1'b1;
            m_own[j]  = m_w[j];
          end
        end else if (tail[m_w[j]]) begin
          m_lock[j] = 1'b0;
        end
      end
    end
  endfunction

  task automatic step();
    #1;
    model_eval();
    chk("input_grant", 64'(o_input_grant), 64'(e_ig));
    chk("output_val",  64'(o_output_val),  64'(e_ov));
    chk("xbar_sel",    64'(o_xbar_sel),    64'(e_sel));
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clr();
    val = '0; head = '0; tail = '0; oreq = '0; en = '1;
  endtask

  task automatic put(input int i, input int j, input bit h, input bit t);
    val[i]     = 1'b1;
    head[i]    = h;
    tail[i]    = t;
    oreq[i]    = '0;
    oreq[i][j] = 1'b1;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    model_update();
    @(negedge clk);

    // Reset held with a live request: everything quiet
    put(1, 2, 1'b1, 1'b1);
    step();
    chk("rst_grant", 64'(o_input_grant), 64'd0);
    adv();
    rst_n = 1'b1;

    // N and S head+tail to E: N then S
    clr(); put(1, 2, 1'b1, 1'b1); put(3, 2, 1'b1, 1'b1);
    step();
    chk("e_sel_n", 64'(o_xbar_sel[2]), 64'd1);
    chk("e_grant_n", 64'(o_input_grant), 64'(5'b01000));
    adv();
    clr(); put(3, 2, 1'b1, 1'b1);
    step();
    chk("e_sel_s", 64'(o_xbar_sel[2]), 64'd3);
    chk("e_grant_s", 64'(o_input_grant), 64'(5'b00010));
    adv();

    // Move C pointer to W, then 4-flit W packet with N contending
    clr(); put(3, 0, 1'b1, 1'b1);
    step(); adv();
    for (int f = 0; f < 4; f++) begin
      clr(); put(4, 0, f == 0, f == 3); put(1, 0, 1'b1, 1'b1);
      step();
      chk("w_pkt_grant", 64'(o_input_grant), 64'(5'b00001));
      chk("w_pkt_sel", 64'(o_xbar_sel[0]), 64'd4);
      adv();
    end
    clr(); put(1, 0, 1'b1, 1'b1);
    step();
    chk("n_after_w", 64'(o_input_grant), 64'(5'b01000));
    adv();

    // Locked W->C with W stalled for 3 cycles
    clr(); put(4, 0, 1'b1, 1'b0); put(1, 0, 1'b1, 1'b1);
    step();
    chk("w_lock_head", 64'(o_input_grant), 64'(5'b00001));
    adv();
    repeat (3) begin
      clr(); put(1, 0, 1'b1, 1'b1);
      step();
      chk("w_stall_grant", 64'(o_input_grant), 64'd0);
      chk("w_stall_oval", 64'(o_output_val), 64'd0);
      adv();
    end
    clr(); put(4, 0, 1'b0, 1'b1); put(1, 0, 1'b1, 1'b1);
    step();
    chk("w_resume", 64'(o_input_grant), 64'(5'b00001));
    adv();
    clr(); put(1, 0, 1'b1, 1'b1);
    step();
    chk("n_after_unlock", 64'(o_input_grant), 64'(5'b01000));
    adv();

    // S output without credit for 2 cycles
    repeat (2) begin
      clr(); en[3] = 1'b0; put(2, 3, 1'b1, 1'b1);
      step();
      chk("s_no_credit", 64'(o_input_grant), 64'd0);
      adv();
    end
    clr(); put(2, 3, 1'b1, 1'b1);
    step();
    chk("s_credit_grant", 64'(o_input_grant), 64'(5'b00100));
    chk("s_credit_sel", 64'(o_xbar_sel[3]), 64'd2);
    adv();

    // All inputs to distinct outputs
    clr();
    for (int i = 0; i < M; i++) put(i, (i + 1) % M, 1'b1, 1'b1);
    step();
    chk("all_grant", 64'(o_input_grant), 64'(5'b11111));
    adv();

    // Reset mid-packet: S locks N output, then reset
    clr(); put(3, 1, 1'b1, 1'b0);
    step();
    chk("s_lock_n", 64'(o_input_grant), 64'(5'b00010));
    adv();
    clr(); put(3, 1, 1'b0, 1'b0); put(1, 1, 1'b1, 1'b1);
    step();
    chk("s_body_n", 64'(o_input_grant), 64'(5'b00010));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_grant", 64'(o_input_grant), 64'd0);
    chk("rst_mid_oval", 64'(o_output_val), 64'd0);
    chk("rst_mid_sel", 64'(o_xbar_sel), 64'd0);
    adv();
    rst_n = 1'b1;
    clr(); put(1, 1, 1'b1, 1'b1);
    step();
    chk("post_rst_grant", 64'(o_input_grant), 64'(5'b01000));
    chk("post_rst_sel", 64'(o_xbar_sel[1]), 64'd1);
    adv();

    // Random traffic with occasional reset pulses
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(99) != 0);
      for (int i = 0; i < M; i++) begin
        val[i]  = ($urandom_range(9) < 7);
        head[i] = ($urandom_range(1) == 1);
        tail[i] = ($urandom_range(1) == 1);
        en[i]   = ($urandom_range(9) < 8);
        oreq[i] = '0;
        oreq[i][$urandom_range(M - 1)] = 1'b1;
      end
      step();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
